// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin front end for a shared pipelined 4-bit multiplier.
// One operand pair is issued per cycle to the external multiplier. A shadow
// pipeline of {valid, id} tags, matched to the multiplier latency, routes each
// product back to its requester as a registered one-hot response.
//
// Handshake: req[i] is a level "valid" that the requester holds with stable
// operands until it sees gnt[i]=1 ("ready") in the same cycle. The transfer
// happens on that cycle's rising edge. In the following cycle the requester
// either drops req[i] or presents its next operand pair. Responses carry no
// back-pressure: rsp_valid[i] is a single-cycle pulse.
module mult_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     gnt,
    output logic [3:0]           mul_a,
    output logic [3:0]           mul_b,
    input  logic [7:0]           mul_z,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_z,
    output logic                 busy
);

    // One extra bit so ptr + offset can exceed N_REQ before the explicit wrap.
    localparam int             CW      = ID_W + 1;
    localparam logic [CW-1:0]  N_REQ_C = CW'(N_REQ);

    // Round-robin pointer: index searched first in the next arbitration.
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;

    // Arbitration result for the current cycle.
    logic             win_found;
    logic [ID_W-1:0]  win_id;

    // Tag shadow pipeline; stage MUL_LAT-1 lines up with mul_z.
    logic [MUL_LAT-1:0]  tag_v_q;
    logic [MUL_LAT-1:0]  tag_v_d;
    logic [ID_W-1:0]     tag_id_q [MUL_LAT];

    logic                last_v;
    logic [ID_W-1:0]     last_id;
    logic                busy_d;

    assign last_v  = tag_v_q[MUL_LAT-1];
    assign last_id = tag_id_q[MUL_LAT-1];

    // Find the first requester at or after ptr_q, wrapping modulo N_REQ.
    // The loop walks offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [CW-1:0] cand;
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        if (!reset && en) begin
            for (int off = N_REQ - 1; off >= 0; off--) begin
                cand = {1'b0, ptr_q} + CW'(off);
                if (cand >= N_REQ_C) begin
                    cand = cand - N_REQ_C;
                end
                if (req[cand[ID_W-1:0]]) begin
                    win_found = 1'b1;
                    win_id    = cand[ID_W-1:0];
                end
            end
        end
    end

    // Decode the winner into the one-hot grant and steer its operands.
    always_comb begin
        gnt   = '0;
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_found && (win_id == ID_W'(i))) begin
                gnt[i] = 1'b1;
                mul_a  = req_a[4*i +: 4];
                mul_b  = req_b[4*i +: 4];
            end
        end
    end

    // Pointer advances to the slot after the winner; wrap is an explicit
    // compare so non-power-of-two N_REQ never relies on bit overflow.
    always_comb begin
        logic [CW-1:0] nxt;
        nxt   = {1'b0, win_id} + CW'(1);
        ptr_d = ptr_q;
        if (win_found) begin
            if (nxt >= N_REQ_C) begin
                ptr_d = '0;
            end else begin
                ptr_d = nxt[ID_W-1:0];
            end
        end
    end

    // Next tag-valid vector: the grant enters stage 0, the rest shift down.
    always_comb begin
        tag_v_d    = '0;
        tag_v_d[0] = win_found;
        for (int k = 1; k < MUL_LAT; k++) begin
            tag_v_d[k] = tag_v_q[k-1];
        end
    end

    // busy mirrors the state that will be held after this edge:
    // any tag in flight, or a response about to be presented.
    assign busy_d = (|tag_v_d) | last_v;

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tag pipeline shifts every cycle independent of en; reset kills
    // in-flight tags so their products are never reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q     <= tag_v_d;
            tag_id_q[0] <= win_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // Response register: capture mul_z when the aligned tag is valid,
    // otherwise pulse nothing and keep the last id/product.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_id    <= '0;
            rsp_z     <= '0;
        end else begin
            rsp_valid <= '0;
            if (last_v) begin
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_valid[i] <= (last_id == ID_W'(i));
                end
                rsp_id <= last_id;
                rsp_z  <= mul_z;
            end
        end
    end

    // Busy flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: doc/mult_rr_arbiter.md
Name: mult_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-stage pipelined 4-bit unsigned multiplier among N_REQ requesters.
- Issues at most one operand pair per cycle into the multiplier and carries a requester tag through a shadow pipeline matched to the multiplier latency.
- Registers each product and returns it to the issuing requester.
- Sits between the requesters and the multiplier instance; the multiplier's own active-low reset is driven by the parent, outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 3, multiplier latency in cycles, from the operand sample edge to the first cycle z is valid.
- ID_W, 2, tag width; must be at least clog2(N_REQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  issue enable; when 0, no new grants, in-flight ops still complete.
- req  in  N_REQ  per-requester request level; held until granted.
- req_a  in  4*N_REQ  packed multiplicands; slice i is bits [4i+3:4i].
- req_b  in  4*N_REQ  packed multipliers; same packing as req_a.
- gnt  out  N_REQ  one-hot grant, combinational; operands accepted this cycle.
- mul_a  out  4  multiplier operand a.
- mul_b  out  4  multiplier operand b.
- mul_z  in  8  multiplier product.
- rsp_valid  out  N_REQ  one-hot, registered; product for requester i is valid this cycle.
- rsp_id  out  ID_W  registered; index of the requester owning rsp_z.
- rsp_z  out  8  registered product.
- busy  out  1  registered; 1 while any op is in flight or a response is pending.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_z=0, busy=0, rr pointer=0, all tag-pipeline valid bits=0.
- While reset=1, gnt is forced to 0, and mul_a/mul_b are forced to 0.
- Arbitration (combinational):
  - Requests are considered only when en=1 and reset=0.
  - Search starts at index ptr and wraps modulo N_REQ; the first index with req=1 wins.
  - At most one gnt bit is set.
  - With no winner: gnt=0 and mul_a=mul_b=0.
  - With winner w: mul_a=req_a slice w and mul_b=req_b slice w.
- Pointer update (registered): on a grant to w, ptr <= (w+1) mod N_REQ. With no grant, ptr holds.
- Requester handshake:
  - A requester drops req, or presents a new operand pair, in the cycle after its gnt.
  - Back-to-back requests from the same requester are legal. They are granted again only after every other active requester has been served.
- Tag pipeline:
  - Holds MUL_LAT stages of {valid, id}.
  - Stage 0 <= {grant_this_cycle, w}; stage k <= stage k-1; shifts every cycle regardless of en.
  - The last stage aligns with mul_z: an op granted in cycle t has mul_z valid in cycle t+MUL_LAT.
- Response (registered, total latency MUL_LAT+1):
  - In cycle t+MUL_LAT+1: rsp_valid has only bit w set, rsp_id=w, rsp_z=mul_z sampled in cycle t+MUL_LAT.
  - When the last stage is invalid: rsp_valid=0, and rsp_z/rsp_id hold their previous values.
- Throughput: one op per cycle sustained; responses return in grant order.
- busy = OR of all tag-stage valid bits OR any rsp_valid bit, registered.
- en falling mid-stream: in-flight ops still produce responses; no new gnt.
- Simultaneous reset and in-flight ops:
  - All tag valids clear, so no rsp_valid for those ops.
  - Stale mul_z values are ignored.
  - ptr returns to 0.
- N_REQ not a power of two: pointer wrap is explicit modulo, never a bit-width overflow.
- Products are unsigned 8-bit, 15*15=225 max; no truncation.

Test Plan:
- Single op: reset, then req[0]=1 with a=3, b=5 for one cycle → gnt[0] in that cycle t; rsp_valid=4'b0001, rsp_id=0, rsp_z=15 in cycle t+4; busy falls in cycle t+5.
- All four requesting with a=i+1, b=15, held until each is granted, ptr=0 → grants in order 0,1,2,3 in consecutive cycles; rsp_z=15,30,45,60 on consecutive cycles with matching one-hot rsp_valid.
- Fairness: req[1] held continuously; req[3] asserted with a=15, b=15 → grants alternate 1,3,1,…; req[3] is granted within 2 cycles and rsp_z=225 for id 3.
- en gating: two ops granted, en drops to 0 the next cycle with req still high → no further gnt; both responses still arrive 4 cycles after their grants.
- Reset mid-flight: grant op a=7, b=7; assert reset for 1 cycle two cycles later → no rsp_valid ever appears for that op; after reset the next grant goes to req[0] if it is requesting.
- Idle: req=0 for 10 cycles → gnt=0, mul_a=mul_b=0, rsp_valid=0, busy=0 throughout.
